// File: rtl/lw_sha_ahb_slave_adapter.sv
// AHB-Lite slave front end for the SHA control block: turns AHB address/data phases into
// single-cycle native write/read strobes, holding DIN/KEY writes until the core acknowledges.
module lw_sha_ahb_slave_adapter #(
    parameter logic [11:0] WAIT_BASE      = 12'h140,
    parameter logic [11:0] WAIT_LIMIT     = 12'h15F,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        hsel_i,
    input  logic [31:0] haddr_i,
    input  logic [1:0]  htrans_i,
    input  logic        hwrite_i,
    input  logic [2:0]  hsize_i,
    input  logic [2:0]  hburst_i,
    input  logic [31:0] hwdata_i,
    input  logic        hready_i,
    output logic        hreadyout_o,
    output logic        hresp_o,
    output logic [31:0] hrdata_o,
    output logic        wr_o,
    input  logic        wr_ack_i,
    output logic [11:0] waddr_o,
    output logic [11:0] wtransaction_cnt_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wbyte_enable_o,
    output logic        rd_o,
    output logic [11:0] raddr_o,
    output logic [11:0] rtransaction_cnt_o,
    output logic [3:0]  rbyte_enable_o,
    input  logic [31:0] rdata_i,
    output logic [1:0]  burst_type_o,
    input  logic        slv_error_i
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD1, S_RD2, S_ERR1, S_ERR2} state_t;

    localparam logic [11:0] TMO_LAST = 12'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [11:0] r_waddr, r_raddr, r_wcnt, r_rcnt, r_beat, r_tmo;
    logic [3:0]  r_wbe, r_rbe;
    logic [1:0]  r_burst;
    logic [31:0] r_hrdata;

    logic [11:0] w_addr, w_beat;
    logic [3:0]  w_be;
    logic [1:0]  w_bt;
    logic        w_accept, w_illegal, w_in_win, w_wr_go, w_unused;

    assign w_addr    = haddr_i[11:0];
    assign w_unused  = ^haddr_i[31:12];
    assign w_accept  = hsel_i && hready_i && htrans_i[1] && hreadyout_o;
    assign w_illegal = (hsize_i > 3'd2) || (hsize_i == 3'd1 && w_addr[0]) ||
                       (hsize_i == 3'd2 && w_addr[1:0] != 2'b00);
    assign w_beat    = (htrans_i == 2'b10) ? 12'd0 : r_beat + 12'd1;
    assign w_in_win  = (r_waddr >= WAIT_BASE) && (r_waddr <= WAIT_LIMIT);
    // A downstream error takes precedence over completing the write.
    assign w_wr_go   = (r_state == S_WR) && !slv_error_i && (!w_in_win || wr_ack_i);

    always_comb begin
        w_be = 4'hF;
        case (hsize_i)
            3'd0:    w_be = 4'b0001 << w_addr[1:0];
            3'd1:    w_be = w_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'hF;
        endcase
    end

    always_comb begin
        w_bt = 2'd2;
        case (hburst_i)
            3'd0:                      w_bt = 2'd0;
            3'd1, 3'd3, 3'd5, 3'd7:    w_bt = 2'd1;
            default:                   w_bt = 2'd2;
        endcase
    end

    always_comb begin
        hreadyout_o = 1'b1;
        hresp_o     = 1'b0;
        wr_o        = 1'b0;
        rd_o        = 1'b0;
        case (r_state)
            S_WR:   begin hreadyout_o = w_wr_go; wr_o = w_wr_go; end
            S_RD1:  begin hreadyout_o = 1'b0; rd_o = 1'b1; end
            S_RD2:  hreadyout_o = !slv_error_i;
            S_ERR1: begin hreadyout_o = 1'b0; hresp_o = 1'b1; end
            S_ERR2: hresp_o = 1'b1;
            default: ;
        endcase
    end

    assign hrdata_o           = (r_state == S_RD2) ? rdata_i : r_hrdata;
    assign wdata_o            = (r_state == S_WR) ? hwdata_i : 32'd0;
    assign waddr_o            = r_waddr;
    assign raddr_o            = r_raddr;
    assign wtransaction_cnt_o = r_wcnt;
    assign rtransaction_cnt_o = r_rcnt;
    assign wbyte_enable_o     = r_wbe;
    assign rbyte_enable_o     = r_rbe;
    assign burst_type_o       = r_burst;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state  <= S_IDLE;
            r_waddr  <= '0;
            r_raddr  <= '0;
            r_wcnt   <= '0;
            r_rcnt   <= '0;
            r_beat   <= '0;
            r_tmo    <= '0;
            r_wbe    <= '0;
            r_rbe    <= '0;
            r_burst  <= '0;
            r_hrdata <= '0;
        end else begin
            r_tmo <= '0;
            if (r_state == S_RD2 && !slv_error_i)
                r_hrdata <= rdata_i;
            if (w_accept) begin
                r_beat  <= w_beat;
                r_burst <= w_bt;
                if (w_illegal) begin
                    r_state <= S_ERR1;
                end else if (hwrite_i) begin
                    r_state <= S_WR;
                    r_waddr <= w_addr;
                    r_wcnt  <= w_beat;
                    r_wbe   <= w_be;
                end else begin
                    r_state <= S_RD1;
                    r_raddr <= w_addr;
                    r_rcnt  <= w_beat;
                    r_rbe   <= w_be;
                end
            end else begin
                case (r_state)
                    S_WR: begin
                        if (w_wr_go)
                            r_state <= S_IDLE;
                        else if (slv_error_i || r_tmo == TMO_LAST)
                            r_state <= S_ERR1;
                        else
                            r_tmo <= r_tmo + 12'd1;
                    end
                    S_RD1:   r_state <= S_RD2;
                    S_RD2:   r_state <= slv_error_i ? S_ERR1 : S_IDLE;
                    S_ERR1:  r_state <= S_ERR2;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
